hdmi_hpd_config_ctrl: RTL and testbench
=======================================

# hdmi_hpd_config_ctrl

Sequencer that sits directly upstream of the HDMI transmitter's I2C register-write engine and owns its `resend` input. It synchronises and debounces the transmitter's hot-plug-detect pin, waits for the sink to settle, and pulses `resend` so the full register table is rewritten. It then holds off the video path for a fixed configuration window. It re-runs the sequence on every replug or software request, and gates the downstream video output enable.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles of synchronised HPD needed to accept a level change (10 ms at 100 MHz).
- `SETTLE_CYCLES`, 20_000_000: delay from accepted HPD-high to the `resend` pulse (200 ms).
- `CONFIG_CYCLES`, 500_000: window after `resend` during which the write engine is considered busy. Covers the full table plus the initial pause.
- `TIMER_W`, 25: width of the shared down-counter. Every cycle parameter must be ≥ 1 and < 2^TIMER_W.

Ports:
- `clk` in 1: single system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `hpd_in` in 1: raw hot-plug-detect pin, asynchronous to `clk`.
- `force_cfg` in 1: single-cycle request to re-run configuration.
- `resend` out 1: to the write engine. Registered, high for exactly one cycle per configuration.
- `video_en` out 1: enables the video output stage.
- `hpd_stable` out 1: debounced HPD level.
- `cfg_done` out 1: high while in ACTIVE.
- `cfg_count` out 8: number of `resend` pulses issued. Saturates at 255.

## Operation
- HPD front end:
  - 2-flop synchroniser on `hpd_in`.
  - Debounce counter clears whenever the synchronised value equals `hpd_stable`.
  - Otherwise it increments. On reaching `DEBOUNCE_CYCLES-1`, `hpd_stable` takes the synchronised value and the counter clears.
- FSM states: UNPLUGGED, SETTLE, KICK, CONFIG, ACTIVE.
  - UNPLUGGED: `hpd_stable`=1 → SETTLE, timer loads `SETTLE_CYCLES-1`. `force_cfg` is ignored.
  - SETTLE: timer decrements. At 0 → KICK.
  - KICK: lasts one cycle. Asserts `resend`, increments `cfg_count`, loads timer with `CONFIG_CYCLES-1` → CONFIG.
  - CONFIG: timer decrements. At 0 → ACTIVE.
  - ACTIVE: `video_en`=1, `cfg_done`=1. Stays until an event.
- Events in SETTLE, KICK, CONFIG or ACTIVE:
  - `hpd_stable`=0 → UNPLUGGED. This wins over every other event in the same cycle.
  - `force_cfg`=1 (and HPD still high) → KICK next cycle. This also restarts an in-progress CONFIG or SETTLE.
- `video_en` and `cfg_done` are Moore outputs decoded from the state register (registered state, no input path).
- An unplug during CONFIG does not stop the write engine; its writes to the unpowered sink are harmless. The replug always issues a fresh `resend`.

## Timing
- Reset values: `resend`=0, `video_en`=0, `hpd_stable`=0, `cfg_done`=0, `cfg_count`=0, state=UNPLUGGED, synchroniser flops=0, timer=0, debounce counter=0.
- Reset assertion clears all of the above immediately, including mid-CONFIG.
- HPD latency: an `hpd_in` edge held steady is reflected on `hpd_stable` 2 + `DEBOUNCE_CYCLES` cycles later.
  - Pulses shorter than `DEBOUNCE_CYCLES` synchronised cycles produce no change.
- `hpd_stable` rise → `resend` high after 1 + `SETTLE_CYCLES` cycles.
- `resend` high → `video_en` high after `CONFIG_CYCLES` + 1 cycles.
- `hpd_stable` fall → `video_en` low 1 cycle later.
- `force_cfg` sampled high in ACTIVE:
  - `video_en` low and `resend` high 1 cycle later.
  - `video_en` high again `CONFIG_CYCLES` + 1 cycles after `resend`.
- `force_cfg` held high re-enters KICK every cycle it is sampled in KICK or CONFIG. Callers must pulse it.

## Structure
- Shared HDMI package holds:
  - the state enum;
  - default cycle constants expressed at 100 MHz;
  - the `CONFIG_CYCLES` lower bound derived from the register-table length × 29 bits × 256 clocks + initial pause.
- One natural sub-module: `hpd_debounce`, containing the synchroniser and debounce counter with parameter `DEBOUNCE_CYCLES`. FSM and timer stay in the top.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `SETTLE_CYCLES`=16, `CONFIG_CYCLES`=32.

1. Release reset with `hpd_in`=1 → `hpd_stable` rises 6 cycles later, single `resend` pulse 17 cycles after that, `video_en` 33 cycles after the pulse, `cfg_count`=1.
2. In ACTIVE, drop `hpd_in` for 3 cycles → no output changes, no `resend`.
3. In ACTIVE, drop `hpd_in` for 10 cycles, then raise it → `video_en` falls 1 cycle after `hpd_stable` falls; replug gives a second `resend` pulse and `cfg_count`=2.
4. `force_cfg` pulse in ACTIVE → `resend` pulse and `video_en`=0 next cycle, `video_en`=1 after 33 cycles. Repeated 300 times → `cfg_count` stays at 255.
5. Unplug mid-CONFIG, and separately `force_cfg` in the same cycle `hpd_stable` falls → UNPLUGGED, no `resend`, `video_en` stays 0.
6. Assert `rst_n` mid-CONFIG → all outputs 0 with no clock edge. On release with `hpd_in`=1 the full sequence from scenario 1 repeats.

Source files
------------

// File: rtl/hdmi_hpd_config_ctrl_pkg.sv
// rtl/hdmi_hpd_config_ctrl_pkg.sv - shared HDMI hot-plug / configuration constants and types
//
// Holds the sequencer state encoding, the default cycle counts at a 100 MHz
// system clock, and the lower bound on the configuration window derived from
// the transmitter register table.
package hdmi_hpd_config_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_UNPLUGGED = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_KICK      = 3'd2,
        ST_CONFIG    = 3'd3,
        ST_ACTIVE    = 3'd4
    } hpd_state_e;

    localparam int unsigned CLK_HZ = 100_000_000;

    // 10 ms debounce, 200 ms sink settle time.
    localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;
    localparam int unsigned DEF_SETTLE_CYCLES   = CLK_HZ / 5;

    // Write engine cost: each table entry is a 29-bit I2C frame
    // (address + register + data + acks) at 256 system clocks per bit,
    // preceded by a 0.5 ms power-up pause.
    localparam int unsigned CFG_TABLE_LEN         = 60;
    localparam int unsigned CFG_BITS_PER_WRITE    = 29;
    localparam int unsigned CFG_CLKS_PER_BIT      = 256;
    localparam int unsigned CFG_INIT_PAUSE_CYCLES = CLK_HZ / 2000;
    localparam int unsigned CFG_MIN_CYCLES =
        CFG_TABLE_LEN * CFG_BITS_PER_WRITE * CFG_CLKS_PER_BIT + CFG_INIT_PAUSE_CYCLES;

    // Round the minimum up to a 5 ms window.
    localparam int unsigned CFG_MARGIN_CYCLES  = 500_000 - CFG_MIN_CYCLES;
    localparam int unsigned DEF_CONFIG_CYCLES  = CFG_MIN_CYCLES + CFG_MARGIN_CYCLES;

    // Wide enough for the 200 ms settle delay.
    localparam int unsigned DEF_TIMER_W = 25;

    // Saturating 8-bit increment for the configuration counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/hdmi_hpd_config_ctrl_hpd_debounce.sv
// rtl/hdmi_hpd_config_ctrl_hpd_debounce.sv - HPD synchroniser and level debouncer
//
// Ports:
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   hpd_in     in  raw hot-plug-detect pin (asynchronous)
//   hpd_stable out debounced HPD level
//
// A level change is accepted only after the synchronised pin differs from
// hpd_stable for DEBOUNCE_CYCLES consecutive cycles.
module hpd_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hpd_in,
    output logic hpd_stable
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync0;
    logic             sync1;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= hpd_in;
            sync1 <= sync0;
        end
    end

    // Any cycle that agrees with the accepted level restarts the count, so
    // only an unbroken run of the opposite level is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            hpd_stable <= 1'b0;
        end else if (sync1 == hpd_stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt        <= '0;
            hpd_stable <= sync1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hdmi_hpd_config_ctrl.sv
// rtl/hdmi_hpd_config_ctrl.sv - HDMI hot-plug driven transmitter configuration sequencer
//
// Ports:
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   hpd_in     in  raw hot-plug-detect pin (asynchronous)
//   force_cfg  in  single-cycle software request to re-run configuration
//   resend     out one-cycle pulse to the I2C write engine
//   video_en   out video output stage enable (ACTIVE only)
//   hpd_stable out debounced HPD level
//   cfg_done   out high while in ACTIVE
//   cfg_count  out number of resend pulses issued, saturating at 255
module hdmi_hpd_config_ctrl
    import hdmi_hpd_config_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int unsigned CONFIG_CYCLES   = DEF_CONFIG_CYCLES,
    parameter int unsigned TIMER_W         = DEF_TIMER_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hpd_in,
    input  logic       force_cfg,
    output logic       resend,
    output logic       video_en,
    output logic       hpd_stable,
    output logic       cfg_done,
    output logic [7:0] cfg_count
);

    localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] CONFIG_LOAD = TIMER_W'(CONFIG_CYCLES - 1);

    hpd_state_e         state;
    logic [TIMER_W-1:0] timer;

    hpd_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_hpd_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .hpd_in    (hpd_in),
        .hpd_stable(hpd_stable)
    );

    // resend is raised on the edge that enters KICK, so it is high exactly
    // while the state register holds KICK. Unplug is checked before the
    // software request so it always wins; a replug then walks the full
    // SETTLE/KICK path and issues a fresh resend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_UNPLUGGED;
            timer     <= '0;
            resend    <= 1'b0;
            cfg_count <= '0;
        end else begin
            resend <= 1'b0;
            if (state == ST_UNPLUGGED) begin
                if (hpd_stable) begin
                    state <= ST_SETTLE;
                    timer <= SETTLE_LOAD;
                end
            end else if (!hpd_stable) begin
                state <= ST_UNPLUGGED;
                timer <= '0;
            end else if (force_cfg) begin
                state     <= ST_KICK;
                resend    <= 1'b1;
                cfg_count <= sat_inc8(cfg_count);
            end else begin
                case (state)
                    ST_SETTLE: begin
                        if (timer == '0) begin
                            state     <= ST_KICK;
                            resend    <= 1'b1;
                            cfg_count <= sat_inc8(cfg_count);
                        end else begin
                            timer <= timer - TIMER_W'(1);
                        end
                    end
                    ST_KICK: begin
                        state <= ST_CONFIG;
                        timer <= CONFIG_LOAD;
                    end
                    ST_CONFIG: begin
                        if (timer == '0) begin
                            state <= ST_ACTIVE;
                        end else begin
                            timer <= timer - TIMER_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign video_en = (state == ST_ACTIVE);
    assign cfg_done = (state == ST_ACTIVE);

endmodule

// File: tb/tb_hdmi_hpd_config_ctrl.sv
// tb/tb_hdmi_hpd_config_ctrl.sv - directed self-checking bench for hdmi_hpd_config_ctrl
module tb_hdmi_hpd_config_ctrl;

    localparam int unsigned D = 4;
    localparam int unsigned S = 16;
    localparam int unsigned C = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hpd_in;
    logic       force_cfg;
    logic       resend;
    logic       video_en;
    logic       hpd_stable;
    logic       cfg_done;
    logic [7:0] cfg_count;

    int checks = 0;
    int passes = 0;
    int n_resend = 0;

    hdmi_hpd_config_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .SETTLE_CYCLES  (S),
        .CONFIG_CYCLES  (C),
        .TIMER_W        (25)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hpd_in    (hpd_in),
        .force_cfg (force_cfg),
        .resend    (resend),
        .video_en  (video_en),
        .hpd_stable(hpd_stable),
        .cfg_done  (cfg_done),
        .cfg_count (cfg_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resend === 1'b1) n_resend++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic sig(input int s);
        case (s)
            0:       return hpd_stable;
            1:       return resend;
            default: return video_en;
        endcase
    endfunction

    // Number of negedges until sig(s) == v, or -1 if not seen within max.
    task automatic cycles_until(input int s, input logic v, input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sig(s) !== v && n < max);
        if (sig(s) !== v) n = -1;
    endtask

    task automatic pulse_force();
        force_cfg = 1'b1;
        @(negedge clk);
        force_cfg = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        hpd_in    = 1'b1;
        force_cfg = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({resend, video_en, hpd_stable, cfg_done, cfg_count} !== 12'h000)
            $display("FAIL reset_outputs: got %b want 0", {resend, video_en, hpd_stable, cfg_done, cfg_count});
        else passes++;
    endtask

    // Releases reset with hpd_in high and follows the whole power-up sequence.
    task automatic test_power_up(input string tag);
        int n;
        int base;
        base  = n_resend;
        rst_n = 1'b1;
        cycles_until(0, 1'b1, 20, n);
        checks++;
        if (n !== 6) $display("FAIL %s_hpd_latency: got %0d want 6", tag, n);
        else passes++;
        cycles_until(1, 1'b1, 40, n);
        checks++;
        if (n !== 17) $display("FAIL %s_resend_latency: got %0d want 17", tag, n);
        else passes++;
        cycles_until(2, 1'b1, 60, n);
        checks++;
        if (n !== 33) $display("FAIL %s_video_latency: got %0d want 33", tag, n);
        else passes++;
        checks++;
        if ({cfg_done, cfg_count} !== {1'b1, 8'd1})
            $display("FAIL %s_done_count: got done=%b count=%0d want done=1 count=1", tag, cfg_done, cfg_count);
        else passes++;
        checks++;
        if (n_resend - base !== 1) $display("FAIL %s_single_resend: got %0d want 1", tag, n_resend - base);
        else passes++;
    endtask

    task automatic test_glitch();
        int bad;
        int base;
        bad    = 0;
        base   = n_resend;
        hpd_in = 1'b0;
        repeat (3) @(negedge clk);
        hpd_in = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (hpd_stable !== 1'b1 || video_en !== 1'b1 || cfg_done !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0 || n_resend !== base)
            $display("FAIL glitch_ignored: bad_cycles=%0d resends=%0d want 0 and 0", bad, n_resend - base);
        else passes++;
    endtask

    task automatic test_unplug_replug();
        int n;
        hpd_in = 1'b0;
        cycles_until(0, 1'b0, 20, n);
        checks++;
        if (n !== 6 || video_en !== 1'b1)
            $display("FAIL unplug_hpd_fall: got n=%0d video_en=%b want 6 and 1", n, video_en);
        else passes++;
        cycles_until(2, 1'b0, 5, n);
        checks++;
        if (n !== 1) $display("FAIL unplug_video_fall: got %0d want 1", n);
        else passes++;
        repeat (3) @(negedge clk);
        hpd_in = 1'b1;
        cycles_until(0, 1'b1, 20, n);
        cycles_until(1, 1'b1, 40, n);
        checks++;
        if (n !== 17) $display("FAIL replug_resend: got %0d want 17", n);
        else passes++;
        checks++;
        if (cfg_count !== 8'd2) $display("FAIL replug_count: got %0d want 2", cfg_count);
        else passes++;
        cycles_until(2, 1'b1, 60, n);
        checks++;
        if (n !== 33) $display("FAIL replug_video: got %0d want 33", n);
        else passes++;
    endtask

    task automatic test_force();
        int n;
        int bad;
        int exp_cnt;
        pulse_force();
        checks++;
        if ({resend, video_en} !== 2'b10)
            $display("FAIL force_kick: got resend=%b video_en=%b want 1 0", resend, video_en);
        else passes++;
        checks++;
        if (cfg_count !== 8'd3) $display("FAIL force_count: got %0d want 3", cfg_count);
        else passes++;
        cycles_until(2, 1'b1, 40, n);
        checks++;
        if (n !== 33) $display("FAIL force_video: got %0d want 33", n);
        else passes++;
        bad = 0;
        for (int i = 0; i < 299; i++) begin
            pulse_force();
            exp_cnt = (4 + i > 255) ? 255 : 4 + i;
            if (resend !== 1'b1 || video_en !== 1'b0 || cfg_count !== exp_cnt[7:0]) bad++;
            cycles_until(2, 1'b1, 40, n);
            if (n !== 33) bad++;
        end
        checks++;
        if (bad !== 0) $display("FAIL force_repeat: got %0d bad iterations want 0", bad);
        else passes++;
        checks++;
        if (cfg_count !== 8'd255) $display("FAIL count_saturate: got %0d want 255", cfg_count);
        else passes++;
    endtask

    task automatic test_unplug_config();
        int n;
        int bad;
        int base;
        pulse_force();
        repeat (5) @(negedge clk);
        hpd_in = 1'b0;
        cycles_until(0, 1'b0, 20, n);
        base = n_resend;
        bad  = 0;
        repeat (40) begin
            @(negedge clk);
            if (video_en !== 1'b0 || cfg_done !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0 || n_resend !== base)
            $display("FAIL unplug_in_config: bad_cycles=%0d resends=%0d want 0 and 0", bad, n_resend - base);
        else passes++;
        hpd_in = 1'b1;
        cycles_until(1, 1'b1, 40, n);
        checks++;
        if (n !== 23) $display("FAIL unplug_config_replug: got %0d want 23", n);
        else passes++;
        cycles_until(2, 1'b1, 60, n);
        checks++;
        if (n !== 33) $display("FAIL unplug_config_video: got %0d want 33", n);
        else passes++;
    endtask

    task automatic test_force_with_unplug();
        int n;
        int bad;
        int base;
        hpd_in = 1'b0;
        cycles_until(0, 1'b0, 20, n);
        base = n_resend;
        pulse_force();
        bad = 0;
        repeat (40) begin
            if (video_en !== 1'b0 || cfg_done !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0 || n_resend !== base)
            $display("FAIL unplug_beats_force: bad_cycles=%0d resends=%0d want 0 and 0", bad, n_resend - base);
        else passes++;
    endtask

    task automatic test_reset_mid_config();
        int n;
        hpd_in = 1'b1;
        cycles_until(1, 1'b1, 40, n);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({resend, video_en, hpd_stable, cfg_done, cfg_count} !== 12'h000)
            $display("FAIL async_reset: got %b want 0", {resend, video_en, hpd_stable, cfg_done, cfg_count});
        else passes++;
        repeat (2) @(negedge clk);
        test_power_up("rerun");
    endtask

    initial begin
        test_reset();
        test_power_up("pwrup");
        test_glitch();
        test_unplug_replug();
        test_force();
        test_unplug_config();
        test_force_with_unplug();
        test_reset_mid_config();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
